writeback_unit: RTL and testbench

//   Result-side counterpart of the ALU operand-select path. Picks the register-file write

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/load_extract.sv | 53 +++++
 rtl/writeback_unit.sv | 140 ++++++++++++++
 tb/tb_writeback_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared constants and types for the writeback stage
//                (writeback-select codes, load funct3 codes, FSM states).
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Writeback source select
    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;
    localparam logic [1:0] WB_SEL_IMM = 2'b11;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Writeback FSM: IDLE handles same-cycle writes, WAIT covers BRAM latency
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wb_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/load_extract.sv
`default_nettype none
// ============================================================================
//  Module      : load_extract
//  Description : Little-endian byte/half/word extraction of a BRAM read word,
//                with sign/zero extension and misalignment/illegal-type fault.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_extract
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      addr,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            fault
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Select the addressed byte lane and halfword lane
    always_comb begin
        byte_lane = word[{addr, 3'b000} +: 8];
        half_lane = addr[1] ? word[31:16] : word[15:0];
    end

    // Extend per load type and flag misaligned or unsupported loads
    always_comb begin
        data  = '0;
        fault = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3_LBU: data = {{(XLEN-8){1'b0}}, byte_lane};
            F3_LH: begin
                data  = {{(XLEN-16){half_lane[15]}}, half_lane};
                fault = addr[0];
            end
            F3_LHU: begin
                data  = {{(XLEN-16){1'b0}}, half_lane};
                fault = addr[0];
            end
            F3_LW: begin
                data  = word;
                fault = (addr != 2'b00);
            end
            default: fault = 1'b1;
        endcase
    end

endmodule : load_extract
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_unit
//  Description : Register-file writeback select. Non-load results are written
//                in the same cycle; loads stall the PC for LOAD_LATENCY cycles
//                while the synchronous BRAM read completes, then commit.
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_unit
    import riscv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_LATENCY = 1      // legal range 1..3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Instr_Valid,
    input  logic                  Reg_Write,
    input  logic [1:0]            WB_Sel,
    input  logic [REG_ADDR_W-1:0] Rd,
    input  logic [2:0]            Funct3,
    input  logic [XLEN-1:0]       ALU_Result,
    input  logic [XLEN-1:0]       PC_Plus_4,
    input  logic [XLEN-1:0]       Imm,
    input  logic [XLEN-1:0]       Mem_Rd_Data,
    output logic                  RF_We,
    output logic [REG_ADDR_W-1:0] RF_Waddr,
    output logic [XLEN-1:0]       RF_Wdata,
    output logic                  Stall,
    output logic                  Load_Fault
);

    // Counter starts at LATENCY-1 so the commit cycle lands exactly LATENCY cycles after issue
    localparam logic [1:0] CNT_INIT = 2'(LOAD_LATENCY - 1);

    wb_state_t             state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            addr_q, addr_d;

    logic [XLEN-1:0]       ext_data;
    logic                  ext_fault;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [XLEN-1:0]       rf_wdata;
    logic                  stall;
    logic                  load_fault;

    // Extraction always works on the captured load attributes
    load_extract #(
        .XLEN   (XLEN)
    ) u_load_extract (
        .word   (Mem_Rd_Data),
        .addr   (addr_q),
        .funct3 (f3_q),
        .data   (ext_data),
        .fault  (ext_fault)
    );

    // Next-state, capture and writeback decision
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        rf_we      = 1'b0;
        rf_waddr   = Rd;
        rf_wdata   = '0;
        stall      = 1'b0;
        load_fault = 1'b0;
        case (state_q)
            IDLE: begin
                case (WB_Sel)
                    WB_SEL_ALU: rf_wdata = ALU_Result;
                    WB_SEL_PC4: rf_wdata = PC_Plus_4;
                    WB_SEL_IMM: rf_wdata = Imm;
                    default:    rf_wdata = '0;
                endcase
                if (Instr_Valid && Reg_Write) begin
                    if (WB_Sel == WB_SEL_MEM) begin
                        stall   = 1'b1;
                        rd_d    = Rd;
                        f3_d    = Funct3;
                        addr_d  = ALU_Result[1:0];
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end else begin
                        rf_we = (Rd != '0);
                    end
                end
            end
            WAIT: begin
                // Upstream inputs are held but ignored here, so the load is never re-issued
                rf_waddr = rd_q;
                rf_wdata = ext_data;
                if (cnt_q != 2'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    rf_we      = (rd_q != '0) && !ext_fault;
                    load_fault = ext_fault;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and capture registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            rd_q    <= '0;
            f3_q    <= 3'd0;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
        end
    end

    // Outputs held quiet while reset is asserted, including an abandoned load
    always_comb begin
        RF_We      = rst ? 1'b0 : rf_we;
        RF_Waddr   = rst ? '0   : rf_waddr;
        RF_Wdata   = rst ? '0   : rf_wdata;
        Stall      = rst ? 1'b0 : stall;
        Load_Fault = rst ? 1'b0 : load_fault;
    end

endmodule : writeback_unit
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_unit
//  Description : Self-checking bench for writeback_unit. A LOAD_LATENCY=1
//                instance runs a vector table with a write scoreboard; a
//                LOAD_LATENCY=3 instance runs the multi-cycle load and
//                mid-load reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst1, rst3;
    logic        iv1, iv3;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] alu, pc4, imm, mem;

    logic        we1, st1, f1, we3, st3, f3;
    logic [4:0]  wa1, wa3;
    logic [31:0] wd1, wd3;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    writeback_unit #(.XLEN(32), .REG_ADDR_W(5), .LOAD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst1), .Instr_Valid(iv1), .Reg_Write(reg_write),
        .WB_Sel(wb_sel), .Rd(rd), .Funct3(funct3), .ALU_Result(alu),
        .PC_Plus_4(pc4), .Imm(imm), .Mem_Rd_Data(mem),
        .RF_We(we1), .RF_Waddr(wa1), .RF_Wdata(wd1), .Stall(st1), .Load_Fault(f1)
    );

    writeback_unit #(.XLEN(32), .REG_ADDR_W(5), .LOAD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst3), .Instr_Valid(iv3), .Reg_Write(reg_write),
        .WB_Sel(wb_sel), .Rd(rd), .Funct3(funct3), .ALU_Result(alu),
        .PC_Plus_4(pc4), .Imm(imm), .Mem_Rd_Data(mem),
        .RF_We(we3), .RF_Waddr(wa3), .RF_Wdata(wd3), .Stall(st3), .Load_Fault(f3)
    );

    typedef struct {
        logic        iv;
        logic        rw;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] mem;
        logic        e_st;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_f;
    } vec_t;

    vec_t         tbl[$];
    logic [36:0]  sb[$];   // expected {waddr, wdata} of each register write

    function automatic vec_t mk(logic v, logic w, logic [1:0] s, logic [4:0] r, logic [2:0] f,
                                logic [31:0] a, logic [31:0] m, logic est, logic ewe,
                                logic [4:0] ewa, logic [31:0] ewd, logic ef);
        vec_t x;
        x.iv = v; x.rw = w; x.sel = s; x.rd = r; x.f3 = f; x.alu = a; x.mem = m;
        x.e_st = est; x.e_we = ewe; x.e_wa = ewa; x.e_wd = ewd; x.e_f = ef;
        return x;
    endfunction

    task automatic chk(input string nm, input bit d3, input logic est, input logic ewe,
                       input logic [4:0] ewa, input logic [31:0] ewd, input logic ef,
                       input bit cmp_wd);
        logic        st, we, f;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [39:0] act, exp;
        st = d3 ? st3 : st1;  we = d3 ? we3 : we1;  f = d3 ? f3 : f1;
        wa = d3 ? wa3 : wa1;  wd = d3 ? wd3 : wd1;
        act = {st, we, f, wa, (cmp_wd ? wd  : 32'h0)};
        exp = {est, ewe, ef, ewa, (cmp_wd ? ewd : 32'h0)};
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got stall=%b we=%b fault=%b waddr=%0d wdata=%h, expected stall=%b we=%b fault=%b waddr=%0d wdata=%h",
                      nm, st, we, f, wa, wd, est, ewe, ef, ewa, ewd);
    endtask

    task automatic drive(input logic v1, input logic v3, input logic w, input logic [1:0] s,
                         input logic [4:0] r, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] m);
        iv1 = v1; iv3 = v3; reg_write = w; wb_sel = s; rd = r; funct3 = f; alu = a; mem = m;
    endtask

    // Full LW on the latency-3 instance: three stall cycles, then the commit
    task automatic lw3(input string nm);
        drive(1'b0, 1'b1, 1'b1, 2'b01, 5'd6, 3'b010, 32'h0000_3000, 32'hDEAD_BEEF);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("%s_stall%0d", nm, c), 1'b1, 1'b1, 1'b0, 5'd6, 32'h0, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk($sformatf("%s_commit", nm), 1'b1, 1'b0, 1'b1, 5'd6, 32'hDEAD_BEEF, 1'b0, 1'b1);
        @(posedge clk); #1;
        iv3 = 1'b0;
    endtask

    initial begin
        logic [31:0] m;
        logic [36:0] e;
        m = 32'h80FF_7F01;
        pc4 = 32'h0000_0104;
        imm = 32'hABCD_E000;

        // Stimulus table for the latency-1 instance; loads take two rows
        tbl.push_back(mk(1,1,2'b00,5'd5, 3'b000,32'h0000_1234,m, 0,1,5'd5, 32'h0000_1234,0));
        tbl.push_back(mk(0,1,2'b00,5'd5, 3'b000,32'h0000_1234,m, 0,0,5'd5, 32'h0,0));
        tbl.push_back(mk(1,1,2'b01,5'd7, 3'b000,32'h0000_1003,m, 1,0,5'd7, 32'h0,0));
        tbl.push_back(mk(1,1,2'b01,5'd7, 3'b000,32'h0000_1003,m, 0,1,5'd7, 32'hFFFF_FF80,0));
        tbl.push_back(mk(1,1,2'b01,5'd7, 3'b100,32'h0000_1003,m, 1,0,5'd7, 32'h0,0));
        tbl.push_back(mk(1,1,2'b01,5'd7, 3'b100,32'h0000_1003,m, 0,1,5'd7, 32'h0000_0080,0));
        tbl.push_back(mk(1,1,2'b01,5'd7, 3'b001,32'h0000_1001,m, 1,0,5'd7, 32'h0,0));
        tbl.push_back(mk(1,1,2'b01,5'd7, 3'b001,32'h0000_1001,m, 0,0,5'd7, 32'h0,1));
        tbl.push_back(mk(0,0,2'b00,5'd7, 3'b000,32'h0,m,          0,0,5'd7, 32'h0,0));
        tbl.push_back(mk(1,1,2'b10,5'd0, 3'b000,32'h0000_5555,m, 0,0,5'd0, 32'h0,0));
        tbl.push_back(mk(1,1,2'b10,5'd1, 3'b000,32'h0000_5555,m, 0,1,5'd1, 32'h0000_0104,0));
        tbl.push_back(mk(1,1,2'b11,5'd3, 3'b000,32'h0000_5555,m, 0,1,5'd3, 32'hABCD_E000,0));
        tbl.push_back(mk(1,0,2'b01,5'd4, 3'b010,32'h0,m,          0,0,5'd4, 32'h0,0));
        tbl.push_back(mk(1,1,2'b01,5'd9, 3'b101,32'h0000_1002,m, 1,0,5'd9, 32'h0,0));
        tbl.push_back(mk(1,1,2'b01,5'd9, 3'b101,32'h0000_1002,m, 0,1,5'd9, 32'h0000_80FF,0));
        tbl.push_back(mk(1,1,2'b01,5'd9, 3'b001,32'h0000_1002,m, 1,0,5'd9, 32'h0,0));
        tbl.push_back(mk(1,1,2'b01,5'd9, 3'b001,32'h0000_1002,m, 0,1,5'd9, 32'hFFFF_80FF,0));
        tbl.push_back(mk(1,1,2'b01,5'd10,3'b010,32'h0000_2001,m, 1,0,5'd10,32'h0,0));
        tbl.push_back(mk(1,1,2'b01,5'd10,3'b010,32'h0000_2001,m, 0,0,5'd10,32'h0,1));
        tbl.push_back(mk(1,1,2'b01,5'd10,3'b011,32'h0000_2000,m, 1,0,5'd10,32'h0,0));
        tbl.push_back(mk(1,1,2'b01,5'd10,3'b011,32'h0000_2000,m, 0,0,5'd10,32'h0,1));
        tbl.push_back(mk(1,1,2'b01,5'd0, 3'b010,32'h0000_2000,m, 1,0,5'd0, 32'h0,0));
        tbl.push_back(mk(1,1,2'b01,5'd0, 3'b010,32'h0000_2000,m, 0,0,5'd0, 32'h0,0));
        tbl.push_back(mk(1,1,2'b01,5'd11,3'b000,32'h0000_2000,m, 1,0,5'd11,32'h0,0));
        tbl.push_back(mk(1,1,2'b01,5'd11,3'b000,32'h0000_2000,m, 0,1,5'd11,32'h0000_0001,0));
        tbl.push_back(mk(1,1,2'b01,5'd13,3'b000,32'h0000_2001,m, 1,0,5'd13,32'h0,0));
        tbl.push_back(mk(1,1,2'b01,5'd13,3'b000,32'h0000_2001,m, 0,1,5'd13,32'h0000_007F,0));
        tbl.push_back(mk(1,1,2'b01,5'd12,3'b010,32'h0000_2000,m, 1,0,5'd12,32'h0,0));
        tbl.push_back(mk(1,1,2'b01,5'd12,3'b010,32'h0000_2000,m, 0,1,5'd12,32'h80FF_7F01,0));

        // Reset with a live ALU write on the inputs: every output must be forced low
        rst1 = 1'b1; rst3 = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 2'b00, 5'd5, 3'b000, 32'h0000_1234, m);
        @(negedge clk);
        chk("reset_dut1", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        chk("reset_dut3", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        @(posedge clk); #1;
        rst1 = 1'b0; rst3 = 1'b0; iv1 = 1'b0; iv3 = 1'b0;
        @(posedge clk); #1;

        // Table-driven vectors on the latency-1 instance, writes tracked by the scoreboard
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].iv, 1'b0, tbl[i].rw, tbl[i].sel, tbl[i].rd, tbl[i].f3, tbl[i].alu, tbl[i].mem);
            if (tbl[i].e_we) sb.push_back({tbl[i].e_wa, tbl[i].e_wd});
            @(negedge clk);
            chk($sformatf("vec%0d", i), 1'b0, tbl[i].e_st, tbl[i].e_we, tbl[i].e_wa,
                tbl[i].e_wd, tbl[i].e_f, tbl[i].e_we);
            if (we1) begin
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_vec%0d: got unexpected write x%0d=%h, required no write", i, wa1, wd1);
                end else begin
                    e = sb.pop_front();
                    if ({wa1, wd1} === e) n_pass++;
                    else $display("FAIL sb_vec%0d: got write x%0d=%h, required x%0d=%h",
                                  i, wa1, wd1, e[36:32], e[31:0]);
                end
            end
            @(posedge clk); #1;
        end
        iv1 = 1'b0;
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL sb_drain: got %0d writes missing, required 0", sb.size());

        // Latency-3 LW: three stall cycles then commit
        lw3("lw3_a");

        // Reset one cycle into a latency-3 load: outputs drop at once, nothing commits
        drive(1'b0, 1'b1, 1'b1, 2'b01, 5'd6, 3'b010, 32'h0000_3000, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("rstmid_c0", 1'b1, 1'b1, 1'b0, 5'd6, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst3 = 1'b1;
        #1;
        chk("rstmid_async", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        @(posedge clk); #1;
        rst3 = 1'b0; iv3 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rstmid_after%0d", c), 1'b1, 1'b0, 1'b0, 5'd6, 32'h0, 1'b0, 1'b0);
            @(posedge clk); #1;
        end

        // Next load after the aborted one behaves normally
        lw3("lw3_b");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_writeback_unit
`default_nettype wire
